// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the core memory-port arbiter slice.
package riscv_mem_pkg;

    localparam int DEF_XLEN = 32;
    localparam int STRB_W   = DEF_XLEN / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        REQ_IF,
        REQ_LS
    } req_id_t;

    // Width of the latency down-counter; a 1-cycle memory still needs one bit.
    function automatic int lat_cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the load/store port and the RAM port of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/RAM.
interface mem_port_arbiter_if #(
    parameter int XLEN = riscv_mem_pkg::DEF_XLEN
);
    import riscv_mem_pkg::*;

    // Instruction-fetch requester (read-only).
    logic              if_req_valid;
    logic              if_req_ready;
    logic [XLEN-1:0]   if_addr;
    logic              if_resp_valid;
    logic [XLEN-1:0]   if_rdata;

    // Load/store requester.
    logic              ls_req_valid;
    logic              ls_req_ready;
    logic              ls_we;
    logic [XLEN-1:0]   ls_addr;
    logic [XLEN-1:0]   ls_wdata;
    logic [XLEN/8-1:0] ls_wstrb;
    logic              ls_resp_valid;
    logic [XLEN-1:0]   ls_rdata;

    // Single synchronous memory port.
    logic              mem_en;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_resp_valid, if_rdata,
        input  ls_req_valid, ls_we, ls_addr, ls_wdata, ls_wstrb,
        output ls_req_ready, ls_resp_valid, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_resp_valid, if_rdata,
        output ls_req_valid, ls_we, ls_addr, ls_wdata, ls_wstrb,
        input  ls_req_ready, ls_resp_valid, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_select.sv
// Picks which requester gets the memory port and tracks how long fetch has
// been starved by back-to-back load/store grants.
module mem_arb_select
    import riscv_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    if_valid,
    input  logic    ls_valid,
    input  logic    accept,
    output req_id_t grant_id
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             at_limit;

    assign at_limit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    // Load/store wins contention unless fetch has waited through STARVE_LIMIT grants.
    always_comb begin
        grant_id = REQ_IF;
        if (ls_valid && !(if_valid && at_limit)) begin
            grant_id = REQ_LS;
        end
    end

    // Count LS grants that bypassed a waiting fetch; any fetch grant resets the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (accept) begin
            if (grant_id == REQ_IF) begin
                starve_cnt_d = '0;
            end else if (if_valid && !at_limit) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single synchronous RAM port between instruction fetch and the
// load/store unit, one transaction at a time, returning each response to the
// requester that issued it after the fixed memory latency.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int SW    = XLEN / 8;
    localparam int LAT_W = lat_cnt_width(MEM_LATENCY);

    arb_state_t       state_q, state_d;
    req_id_t          owner_q, owner_d;
    req_id_t          grant_id;
    logic             we_q, we_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]    wstrb_q, wstrb_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [XLEN-1:0]  if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]  ls_rdata_q, ls_rdata_d;
    logic [XLEN-1:0]  capture_data;

    logic             in_idle;
    logic             if_ready;
    logic             ls_ready;
    logic             accept;
    logic             issuing;

    // Ready is only offered from IDLE, and never while reset is holding outputs low.
    assign in_idle  = (state_q == IDLE) && rst_n;
    assign if_ready = in_idle && bus.if_req_valid && (grant_id == REQ_IF);
    assign ls_ready = in_idle && bus.ls_req_valid && (grant_id == REQ_LS);
    assign accept   = if_ready || ls_ready;
    assign issuing  = (state_q == ISSUE);

    // Stores acknowledge with zero data rather than whatever the RAM drives.
    assign capture_data = we_q ? '0 : bus.mem_rdata;

    mem_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (bus.if_req_valid),
        .ls_valid (bus.ls_req_valid),
        .accept   (accept),
        .grant_id (grant_id)
    );

    // Transaction FSM: latch on accept, issue for one cycle, count latency, respond.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        lat_cnt_d  = lat_cnt_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    owner_d = grant_id;
                    if (grant_id == REQ_LS) begin
                        we_d    = bus.ls_we;
                        addr_d  = bus.ls_addr;
                        wdata_d = bus.ls_wdata;
                        wstrb_d = bus.ls_wstrb;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = bus.if_addr;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end
                end
            end
            ISSUE: begin
                state_d   = WAIT;
                lat_cnt_d = LAT_W'(MEM_LATENCY - 1);
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = RESP;
                    if (owner_q == REQ_IF) begin
                        if_rdata_d = capture_data;
                    end else begin
                        ls_rdata_d = capture_data;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and returned-data registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= REQ_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            lat_cnt_q  <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            lat_cnt_q  <= lat_cnt_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign bus.if_req_ready  = if_ready;
    assign bus.ls_req_ready  = ls_ready;

    assign bus.mem_en        = issuing;
    assign bus.mem_we        = issuing && we_q;
    assign bus.mem_addr      = issuing ? addr_q  : '0;
    assign bus.mem_wdata     = issuing ? wdata_q : '0;
    assign bus.mem_wstrb     = issuing ? wstrb_q : '0;

    assign bus.if_resp_valid = (state_q == RESP) && (owner_q == REQ_IF);
    assign bus.ls_resp_valid = (state_q == RESP) && (owner_q == REQ_LS);
    assign bus.if_rdata      = if_rdata_q;
    assign bus.ls_rdata      = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for the memory-port arbiter: a table of single transactions
// on a MEM_LATENCY=2 instance, then arbitration, back-to-back, reset and
// MEM_LATENCY=1 sequences.
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    typedef struct {
        logic        isLs;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] expRdata;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Free-running cycle count used to measure accept spacing.
    always @(posedge clk) cycle <= cycle + 1;

    mem_port_arbiter_if #(.XLEN(32)) busA ();
    mem_port_arbiter_if #(.XLEN(32)) busB ();

    mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4), .XLEN(32)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4), .XLEN(32)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB)
    );

    // Initial RAM contents: word at 0x10 holds an instruction, others encode their address.
    function automatic logic [31:0] initWord(input logic [7:0] idx);
        if (idx == 8'd4) return 32'h0010_0093;
        return 32'hC0DE_0000 | {22'd0, idx, 2'b00};
    endfunction

    // RAM model for dutA: two-stage read pipeline, byte-strobed writes.
    logic [31:0] memA [0:255];
    logic        memLoaded = 1'b0;
    logic [31:0] pipeA0, pipeA1, pipeB0;

    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 256; i++) memA[i] <= initWord(8'(i));
            memLoaded <= 1'b1;
        end else if (busA.mem_en && busA.mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (busA.mem_wstrb[b]) memA[busA.mem_addr[9:2]][8*b +: 8] <= busA.mem_wdata[8*b +: 8];
            end
        end
        pipeA0 <= busA.mem_en ? memA[busA.mem_addr[9:2]] : 32'hBAD0_BAD0;
        pipeA1 <= pipeA0;
    end

    // RAM model for dutB: read-only, single-stage read.
    always @(posedge clk) begin
        pipeB0 <= busB.mem_en ? initWord(busB.mem_addr[9:2]) : 32'hBAD0_BAD0;
    end

    assign busA.mem_rdata = pipeA1;
    assign busB.mem_rdata = pipeB0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Runs one request on dutA and checks issue, latency, routing and data hold.
    task automatic applyStimulus(input vec_t v, input int idx);
        bit seen;
        bit seenResp;
        int k;
        @(negedge clk);
        if (v.isLs) begin
            busA.ls_req_valid = 1'b1;
            busA.ls_we        = v.we;
            busA.ls_addr      = v.addr;
            busA.ls_wdata     = v.wdata;
            busA.ls_wstrb     = v.wstrb;
        end else begin
            busA.if_req_valid = 1'b1;
            busA.if_addr      = v.addr;
        end
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            #1;
            if (v.isLs ? busA.ls_req_ready : busA.if_req_ready) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput($sformatf("v%0d_grant", idx), 32'(seen), 32'd1);
        if (seen) @(posedge clk);
        #1;
        busA.if_req_valid = 1'b0;
        busA.ls_req_valid = 1'b0;
        busA.ls_we        = 1'b0;
        busA.ls_wdata     = '0;
        busA.ls_wstrb     = '0;
        if (!seen) return;
        @(negedge clk);
        checkOutput($sformatf("v%0d_mem_en", idx),    32'(busA.mem_en), 32'd1);
        checkOutput($sformatf("v%0d_mem_we", idx),    32'(busA.mem_we), 32'(v.we));
        checkOutput($sformatf("v%0d_mem_addr", idx),  busA.mem_addr, v.addr);
        checkOutput($sformatf("v%0d_mem_wdata", idx), busA.mem_wdata, v.wdata);
        checkOutput($sformatf("v%0d_mem_wstrb", idx), 32'(busA.mem_wstrb), 32'(v.wstrb));
        @(negedge clk);
        checkOutput($sformatf("v%0d_mem_en_off", idx), 32'({busA.mem_en, busA.mem_we}), 32'd0);
        k = 2;
        seenResp = 1'b0;
        while (k < 12 && !seenResp) begin
            if (busA.if_resp_valid || busA.ls_resp_valid) seenResp = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        checkOutput($sformatf("v%0d_latency", idx), 32'(k), 32'd4);
        if (!seenResp) return;
        checkOutput($sformatf("v%0d_owner_resp", idx),
                    32'(v.isLs ? busA.ls_resp_valid : busA.if_resp_valid), 32'd1);
        checkOutput($sformatf("v%0d_other_resp", idx),
                    32'(v.isLs ? busA.if_resp_valid : busA.ls_resp_valid), 32'd0);
        checkOutput($sformatf("v%0d_rdata", idx), v.isLs ? busA.ls_rdata : busA.if_rdata, v.expRdata);
        @(negedge clk);
        checkOutput($sformatf("v%0d_pulse_end", idx),
                    32'({busA.if_resp_valid, busA.ls_resp_valid}), 32'd0);
        checkOutput($sformatf("v%0d_rdata_hold", idx), v.isLs ? busA.ls_rdata : busA.if_rdata, v.expRdata);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [7];
        logic [5:0]  order;
        int          grants;
        bit          bothHigh;
        int          nAcc;
        int          nResp;
        int          accCycle [3];
        logic [31:0] bbAddr [3];
        logic [31:0] bbExp [3];
        bit          accNow;
        bit          seen;
        bit          sawResp;
        int          k;

        vecs[0] = '{isLs: 1'b0, we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0, wstrb: 4'h0, expRdata: 32'h0010_0093};
        vecs[1] = '{isLs: 1'b1, we: 1'b1, addr: 32'h0000_0100, wdata: 32'hDEAD_BEEF, wstrb: 4'hF, expRdata: 32'h0};
        vecs[2] = '{isLs: 1'b1, we: 1'b0, addr: 32'h0000_0100, wdata: 32'h0, wstrb: 4'h0, expRdata: 32'hDEAD_BEEF};
        vecs[3] = '{isLs: 1'b1, we: 1'b1, addr: 32'h0000_0104, wdata: 32'h1122_3344, wstrb: 4'h3, expRdata: 32'h0};
        vecs[4] = '{isLs: 1'b1, we: 1'b0, addr: 32'h0000_0104, wdata: 32'h0, wstrb: 4'h0, expRdata: 32'hC0DE_3344};
        vecs[5] = '{isLs: 1'b0, we: 1'b0, addr: 32'h0000_0020, wdata: 32'h0, wstrb: 4'h0, expRdata: 32'hC0DE_0020};
        vecs[6] = '{isLs: 1'b1, we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0, wstrb: 4'h0, expRdata: 32'h0010_0093};

        busA.if_req_valid = 1'b0; busA.if_addr = '0;
        busA.ls_req_valid = 1'b0; busA.ls_we = 1'b0; busA.ls_addr = '0;
        busA.ls_wdata = '0; busA.ls_wstrb = '0;
        busB.if_req_valid = 1'b0; busB.if_addr = '0;
        busB.ls_req_valid = 1'b0; busB.ls_we = 1'b0; busB.ls_addr = '0;
        busB.ls_wdata = '0; busB.ls_wstrb = '0;

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkOutput("rst_readys", 32'({busA.if_req_ready, busA.ls_req_ready}), 32'd0);
        checkOutput("rst_resps", 32'({busA.if_resp_valid, busA.ls_resp_valid}), 32'd0);
        checkOutput("rst_mem_ctl", 32'({busA.mem_en, busA.mem_we, busA.mem_wstrb}), 32'd0);
        checkOutput("rst_mem_addr", busA.mem_addr, 32'd0);
        checkOutput("rst_if_rdata", busA.if_rdata, 32'd0);
        checkOutput("rst_ls_rdata", busA.ls_rdata, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single-transaction table");
        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

        $display("[TB] contention with starvation guard");
        @(negedge clk);
        busA.if_req_valid = 1'b1; busA.if_addr = 32'h10;
        busA.ls_req_valid = 1'b1; busA.ls_we = 1'b0; busA.ls_addr = 32'h100;
        grants = 0; bothHigh = 1'b0; order = '0;
        for (int t = 0; t < 80 && grants < 6; t++) begin
            #1;
            if (busA.if_req_ready && busA.ls_req_ready) bothHigh = 1'b1;
            if (busA.ls_req_ready) begin
                order[grants] = 1'b1; grants++;
            end else if (busA.if_req_ready) begin
                order[grants] = 1'b0; grants++;
            end
            @(negedge clk);
        end
        busA.if_req_valid = 1'b0;
        busA.ls_req_valid = 1'b0;
        checkOutput("starve_grants", 32'(grants), 32'd6);
        checkOutput("starve_exclusive", 32'(bothHigh), 32'd0);
        checkOutput("starve_order", 32'(order), 32'h2F);
        repeat (8) @(negedge clk);

        $display("[TB] back-to-back fetch");
        bbAddr[0] = 32'h20; bbAddr[1] = 32'h24; bbAddr[2] = 32'h28;
        bbExp[0] = 32'hC0DE_0020; bbExp[1] = 32'hC0DE_0024; bbExp[2] = 32'hC0DE_0028;
        nAcc = 0; nResp = 0;
        accCycle[0] = 0; accCycle[1] = 0; accCycle[2] = 0;
        busA.if_req_valid = 1'b1; busA.if_addr = bbAddr[0];
        for (int t = 0; t < 60 && nResp < 3; t++) begin
            #1;
            if (busA.if_resp_valid) begin
                checkOutput($sformatf("bb_rdata%0d", nResp), busA.if_rdata, bbExp[nResp]);
                nResp++;
            end
            accNow = busA.if_req_ready && (nAcc < 3);
            if (accNow) begin
                accCycle[nAcc] = cycle; nAcc++;
            end
            @(posedge clk);
            #1;
            if (accNow) begin
                if (nAcc < 3) busA.if_addr = bbAddr[nAcc];
                else busA.if_req_valid = 1'b0;
            end
            @(negedge clk);
        end
        busA.if_req_valid = 1'b0;
        checkOutput("bb_accepts", 32'(nAcc), 32'd3);
        checkOutput("bb_resps", 32'(nResp), 32'd3);
        checkOutput("bb_spacing01", 32'(accCycle[1] - accCycle[0]), 32'd5);
        checkOutput("bb_spacing12", 32'(accCycle[2] - accCycle[1]), 32'd5);
        repeat (2) @(negedge clk);

        $display("[TB] reset during WAIT");
        busA.ls_req_valid = 1'b1; busA.ls_we = 1'b0; busA.ls_addr = 32'h100;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            #1;
            if (busA.ls_req_ready) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("rw_grant", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        busA.ls_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rw_mem_ctl", 32'({busA.mem_en, busA.mem_we}), 32'd0);
        checkOutput("rw_resps", 32'({busA.if_resp_valid, busA.ls_resp_valid}), 32'd0);
        checkOutput("rw_ls_rdata", busA.ls_rdata, 32'd0);
        checkOutput("rw_if_rdata", busA.if_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sawResp = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (busA.ls_resp_valid || busA.if_resp_valid) sawResp = 1'b1;
        end
        checkOutput("rw_no_resp", 32'(sawResp), 32'd0);
        applyStimulus(vecs[0], 10);

        $display("[TB] MEM_LATENCY=1 instance");
        @(negedge clk);
        busB.if_req_valid = 1'b1; busB.if_addr = 32'h10;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            #1;
            if (busB.if_req_ready) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("l1_grant", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        busB.if_req_valid = 1'b0;
        @(negedge clk);
        checkOutput("l1_mem_en", 32'(busB.mem_en), 32'd1);
        k = 1;
        while (k < 10 && !busB.if_resp_valid) begin
            @(negedge clk);
            k++;
        end
        checkOutput("l1_latency", 32'(k), 32'd3);
        checkOutput("l1_rdata", busB.if_rdata, 32'h0010_0093);
        checkOutput("l1_ls_resp", 32'(busB.ls_resp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single synchronous memory port between the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Sits between the fetch and LSU stages of the core and the unified RAM instantiated in top.
- Serialises requests with one transaction in flight, counts the fixed memory read latency and returns the response to the owning requester.
- Data requests have priority, with a starvation guard for fetch.

Parameters:
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata (≥1).
- STARVE_LIMIT, 4, max consecutive LS grants while fetch is waiting before fetch is forced.
- XLEN, 32, address/data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  XLEN  fetch address (word aligned).
- if_resp_valid  out  1  one-cycle pulse, if_rdata valid.
- if_rdata  out  XLEN  fetched instruction.
- ls_req_valid  in  1  load/store request.
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  XLEN  LS address.
- ls_wdata  in  XLEN  store data.
- ls_wstrb  in  XLEN/8  byte strobes.
- ls_resp_valid  out  1  one-cycle pulse; load data or store ack.
- ls_rdata  out  XLEN  load data; 0 for stores.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_wstrb  out  XLEN/8  memory byte strobes.
- mem_rdata  in  XLEN  memory read data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all outputs 0; starve_cnt=0; latched request cleared.
  - An in-flight transaction is dropped silently, with no resp pulse.
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - ready is combinational: exactly one of if_req_ready/ls_req_ready is high, for the selected requester, only when its valid is high.
  - Never both high. Ready is 0 in every other state.
- Selection:
  - Only one valid → that requester.
  - Both valid → LS, unless starve_cnt == STARVE_LIMIT, then IF.
- Accept:
  - On valid&ready, latch owner id, we, addr, wdata, wstrb (IF: we=0, wstrb=0); next state ISSUE.
- starve_cnt:
  - +1 on an LS accept while if_req_valid=1 (saturating at STARVE_LIMIT).
  - Cleared on any IF accept.
  - Unchanged otherwise.
- ISSUE (1 cycle): mem_en=1, mem_* driven from the latched request. Next state WAIT with lat_cnt=MEM_LATENCY-1.
- WAIT (MEM_LATENCY cycles): mem_en=0.
  - lat_cnt decrements.
  - In the cycle lat_cnt==0, mem_rdata is captured (0 if we) and the FSM moves to RESP.
- RESP (1 cycle): the owner's resp_valid=1 and rdata=captured value. The other resp_valid stays 0. Next state IDLE.
- rdata outputs hold their value after RESP until the next capture.
- Timing:
  - Accept-to-resp latency = MEM_LATENCY+2 cycles.
  - Back-to-back throughput = one transaction per MEM_LATENCY+3 cycles.
- Handshake rule: requesters hold valid and payload stable until ready. The arbiter never drops a pending request. A valid that deasserts before grant is legal and ignored.
- Width: XLEN/8 strobes pass through unchanged. No address alignment checks.
- Simultaneous events:
  - Both valid at the starve limit → IF wins, counter clears.
  - Requests arriving during ISSUE/WAIT/RESP wait for IDLE.

Decomposition:
- Package riscv_mem_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - req_id_t enum {REQ_IF, REQ_LS}.
  - STRB_W = XLEN/8.
- One natural sub-module: mem_arb_select. It holds the combinational IF/LS pick plus the starve_cnt register, with ports clk, rst_n, if_valid, ls_valid, accept, grant_id.

Test Plan (MEM_LATENCY=2, STARVE_LIMIT=4 unless stated):
- IF only, if_addr=0x0000_0010, mem returns 0x0010_0093 → mem_en high 1 cycle after accept; if_resp_valid pulses 4 cycles after accept with if_rdata=0x0010_0093.
- LS store, addr 0x100, wdata 0xDEADBEEF, wstrb 0xF → mem_we=1, mem_wstrb=0xF for exactly one cycle; ls_resp_valid pulse with ls_rdata=0; no if_resp_valid.
- Both valid continuously, LS issues 6 loads → grant order LS, LS, LS, LS, IF, LS; never both readys high.
- Back-to-back IF requests → accepts spaced exactly 5 cycles; each response matches its own address.
- rst_n asserted during WAIT of an LS load → outputs 0 immediately; no ls_resp_valid after release; next IF request completes normally.
- MEM_LATENCY=1 build: IF read → resp 3 cycles after accept, rdata correct.
